// File: rtl/pulse_cdc_sched_pkg.sv
// rtl/pulse_cdc_sched_pkg.sv - shared types and helpers for pulse_cdc_sched
// Contents: scheduler state enum, select-width helper (clog2 floored at 1).
package pulse_cdc_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Width needed to index n items; never returns 0 so n=1/2 still get a bus.
  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pulse_cdc_sched_rr_arbiter.sv
// rtl/pulse_cdc_sched_rr_arbiter.sv - combinational round-robin pick among nonzero counters
// Ports:
//   req         in  N_REQ  requester has pending events
//   ptr         in  SEL_W  last served index; search starts at ptr+1
//   grant_idx   out SEL_W  winning index (0 when nothing pending)
//   grant_valid out 1      some request is set
module rr_arbiter
  import pulse_cdc_sched_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int SEL_W = sel_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] grant_idx,
  output logic             grant_valid
);

  int               idx;
  logic [SEL_W-1:0] idx_s;

  // Walk offsets from farthest to nearest so the closest requester after
  // ptr is the last one written and therefore wins.
  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = 0;
    idx_s       = '0;
    for (int off = N_REQ; off >= 1; off--) begin
      idx = int'(ptr) + off;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      idx_s = SEL_W'(idx);
      if (req[idx_s]) begin
        grant_idx   = idx_s;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pulse_cdc_sched.sv
// rtl/pulse_cdc_sched.sv - round-robin scheduler sharing one pulse CDC channel among N_REQ sources
// Ports:
//   i_clk          in  1      source-domain clock
//   i_rst          in  1      asynchronous active-high reset
//   i_req_pulse    in  N_REQ  single-cycle event pulses, one bit per requester
//   i_clr_overflow in  1      clears all overflow flags
//   o_pulse        out 1      one-cycle pulse into the toggle-based pulse CDC
//   o_sel          out SEL_W  index served by the current/most recent pulse
//   o_pending_any  out 1      registered OR of all counters nonzero
//   o_overflow     out N_REQ  sticky saturation flags
// Build option: PULSE_CDC_SCHED_OVF_EN enables the sticky overflow flags;
// without it o_overflow is 0 and counters saturate silently.
module pulse_cdc_sched
  import pulse_cdc_sched_pkg::*;
#(
  parameter  int N_REQ   = 4,
  parameter  int CNT_W   = 4,
  parameter  int MIN_GAP = 6,
  localparam int SEL_W   = sel_w(N_REQ)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_REQ-1:0] i_req_pulse,
  input  logic             i_clr_overflow,
  output logic             o_pulse,
  output logic [SEL_W-1:0] o_sel,
  output logic             o_pending_any,
  output logic [N_REQ-1:0] o_overflow
);

  localparam int               GAP_W    = sel_w(MIN_GAP);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  // ISSUE and the final IDLE cycle take two of the MIN_GAP slots; HOLD
  // spends MIN_GAP-2 cycles counting GAP_LOAD down to zero.
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP - 3);
  localparam logic [SEL_W-1:0] PTR_RST  = SEL_W'(N_REQ - 1);

  state_t           state_q, state_d;
  logic [N_REQ-1:0] nz;
  logic [N_REQ-1:0] sat;
  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] win_idx;
  logic             win_valid;
  logic [GAP_W-1:0] gap_q;
  logic             load_sel;
  logic             issue;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req         (nz),
    .ptr         (ptr_q),
    .grant_idx   (win_idx),
    .grant_valid (win_valid)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_valid) state_d = ISSUE;
      ISSUE:   state_d = HOLD;
      HOLD:    if (gap_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load_sel = (state_q == IDLE) && win_valid;
    issue    = (state_q == ISSUE);
  end

  // o_sel moves only when a new winner is latched, so it is settled a
  // cycle before o_pulse and holds until the next IDLE->ISSUE edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_sel         <= '0;
      ptr_q         <= PTR_RST;
      gap_q         <= '0;
      o_pulse       <= 1'b0;
      o_pending_any <= 1'b0;
    end else begin
      if (load_sel) begin
        o_sel <= win_idx;
      end
      if (issue) begin
        ptr_q <= o_sel;
        gap_q <= GAP_LOAD;
      end else if ((state_q == HOLD) && (gap_q != '0)) begin
        gap_q <= gap_q - 1'b1;
      end
      o_pulse       <= issue;
      o_pending_any <= |nz;
    end
  end

  for (genvar i = 0; i < N_REQ; i++) begin : g_cnt
    logic [CNT_W-1:0] cnt;
    logic             inc;
    logic             dec;

    assign inc    = i_req_pulse[i];
    assign dec    = issue && (o_sel == SEL_W'(i));
    assign sat[i] = inc && !dec && (cnt == CNT_MAX);
    assign nz[i]  = (cnt != '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        cnt <= '0;
      end else if (inc && !dec && !sat[i]) begin
        cnt <= cnt + 1'b1;
      end else if (dec && !inc) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

`ifdef PULSE_CDC_SCHED_OVF_EN
  // A saturation in the same cycle as a clear keeps its flag set.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_overflow <= '0;
    end else begin
      o_overflow <= (i_clr_overflow ? '0 : o_overflow) | sat;
    end
  end
`else
  logic unused_ovf;
  assign unused_ovf = i_clr_overflow ^ (|sat);
  assign o_overflow = '0;
`endif

endmodule

// File: tb/tb_pulse_cdc_sched.sv
// tb/tb_pulse_cdc_sched.sv - self-checking bench for pulse_cdc_sched with behavioural model and CDC scoreboard
module tb_pulse_cdc_sched;

  localparam int N    = 4;
  localparam int GAP  = 6;
  localparam int MAXC = 15;
`ifdef PULSE_CDC_SCHED_OVF_EN
  localparam int OVF_ON = 1;
`else
  localparam int OVF_ON = 0;
`endif

  logic         clk = 1'b0;
  logic         dclk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] req = '0;
  logic         clr = 1'b0;
  logic         o_pulse;
  logic [1:0]   o_sel;
  logic         o_pending_any;
  logic [N-1:0] o_overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit cmp_en = 1'b0;

  pulse_cdc_sched dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req_pulse    (req),
    .i_clr_overflow (clr),
    .o_pulse        (o_pulse),
    .o_sel          (o_sel),
    .o_pending_any  (o_pending_any),
    .o_overflow     (o_overflow)
  );

  always #5 clk = ~clk;
  initial begin
    #2;
    forever #15 dclk = ~dclk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Behavioural model: a decision may happen once everything is idle and the
  // previous decision is MIN_GAP cycles old; the winner shows on o_sel the
  // next cycle, is decremented that cycle, and pulses the cycle after.
  int           m_cnt[N];
  int           m_acc[N];
  int           m_sel, m_ptr, mcyc, issue_cyc, next_dec, dec_idx, j;
  bit           m_pulse, m_pend, any, found, acc_en;
  logic [N-1:0] m_ovf, setv;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      m_sel = 0; m_ptr = N - 1; mcyc = 0; issue_cyc = -1; next_dec = 0;
      m_pulse = 0; m_pend = 0; m_ovf = '0;
    end else begin
      dec_idx = (mcyc == issue_cyc) ? m_sel : -1;
      m_pulse = (mcyc == issue_cyc);
      any = 0;
      for (int i = 0; i < N; i++) if (m_cnt[i] != 0) any = 1;
      m_pend = any;
      if (mcyc >= next_dec && any) begin
        found = 0;
        for (int off = 1; off <= N; off++) begin
          j = (m_ptr + off) % N;
          if (!found && m_cnt[j] != 0) begin
            found = 1;
            m_sel = j;
          end
        end
        m_ptr = m_sel;
        issue_cyc = mcyc + 1;
        next_dec = mcyc + GAP;
      end
      setv = '0;
      for (int i = 0; i < N; i++) begin
        if (req[i] && i != dec_idx) begin
          if (m_cnt[i] == MAXC) setv[i] = 1'b1;
          else begin
            m_cnt[i]++;
            if (acc_en) m_acc[i]++;
          end
        end else if (req[i]) begin
          if (acc_en) m_acc[i]++;
        end else if (i == dec_idx) begin
          m_cnt[i]--;
        end
      end
      if (OVF_ON != 0) m_ovf = (clr ? '0 : m_ovf) | setv;
      mcyc++;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      if (rst) begin
        check("rst_pulse", 32'(o_pulse), 32'd0);
        check("rst_sel", 32'(o_sel), 32'd0);
        check("rst_pend", 32'(o_pending_any), 32'd0);
        check("rst_ovf", 32'(o_overflow), 32'd0);
      end else begin
        check("pulse", 32'(o_pulse), 32'(m_pulse));
        check("sel", 32'(o_sel), 32'(m_sel));
        check("pending", 32'(o_pending_any), 32'(m_pend));
        check("overflow", 32'(o_overflow), 32'(m_ovf));
      end
    end
  end

  // Pulse log plus toggle-based CDC model into a 3x slower destination.
  int   plog_cyc[$];
  int   plog_sel[$];
  int   selq[$];
  int   rcv[N];
  int   rcv_total = 0, tog_cnt = 0, underflow = 0, ridx;
  logic src_tog = 1'b0, s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;

  always @(negedge clk) begin
    if (!rst && o_pulse === 1'b1) begin
      plog_cyc.push_back(cyc);
      plog_sel.push_back(int'(o_sel));
      selq.push_back(int'(o_sel));
      src_tog = ~src_tog;
      tog_cnt++;
    end
  end

  always @(posedge dclk) begin
    s1 <= src_tog;
    s2 <= s1;
    s3 <= s2;
    if (s2 != s3) begin
      if (selq.size() > 0) begin
        ridx = selq.pop_front();
        rcv[ridx]++;
      end else begin
        underflow++;
      end
      rcv_total++;
    end
  end

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    tick(2);
    rst = 1'b0;
    plog_cyc.delete();
    plog_sel.delete();
  endtask

  int t0, n1;

  initial begin
    #1 rst = 1'b1;
    #1;
    check("init_pulse", 32'(o_pulse), 32'd0);
    check("init_sel", 32'(o_sel), 32'd0);
    check("init_pend", 32'(o_pending_any), 32'd0);
    check("init_ovf", 32'(o_overflow), 32'd0);
    cmp_en = 1'b1;
    tick(2);
    rst = 1'b0;

    // Single event on requester 2.
    do_reset();
    tick(3);
    t0 = cyc;
    req = 4'b0100;
    tick(1);
    req = '0;
    tick(1);
    @(negedge clk);
    check("single_sel_t2", 32'(o_sel), 32'd2);
    check("single_nopulse_t2", 32'(o_pulse), 32'd0);
    tick(1);
    @(negedge clk);
    check("single_pulse_t3", 32'(o_pulse), 32'd1);
    tick(8);
    @(negedge clk);
    check("single_pend_after", 32'(o_pending_any), 32'd0);
    check("single_count", 32'(plog_cyc.size()), 32'd1);
    if (plog_cyc.size() >= 1) check("single_cycle", 32'(plog_cyc[0] - t0), 32'd3);

    // Simultaneous burst on all requesters.
    do_reset();
    tick(3);
    t0 = cyc;
    req = 4'b1111;
    tick(1);
    req = '0;
    tick(30);
    check("burst_count", 32'(plog_cyc.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < plog_cyc.size()) begin
        check("burst_cycle", 32'(plog_cyc[k] - t0), 32'(3 + 6 * k));
        check("burst_sel", 32'(plog_sel[k]), 32'(k));
      end
    end

    // Increment coinciding with the issue decrement of requester 0.
    do_reset();
    tick(3);
    t0 = cyc;
    req = 4'b0001;
    tick(1);
    req = '0;
    tick(1);
    req = 4'b0001;
    tick(1);
    req = '0;
    tick(20);
    check("incdec_count", 32'(plog_cyc.size()), 32'd2);
    if (plog_cyc.size() >= 2) begin
      check("incdec_first", 32'(plog_cyc[0] - t0), 32'd3);
      check("incdec_second", 32'(plog_cyc[1] - t0), 32'd9);
    end
    check("incdec_ovf", 32'(o_overflow), 32'd0);

    // Saturation: 20 back-to-back pulses on requester 1; 2 are lost.
    do_reset();
    tick(3);
    t0 = cyc;
    req = 4'b0010;
    tick(20);
    req = '0;
    tick(5);
    @(negedge clk);
    check("sat_ovf1", 32'(o_overflow[1]), 32'(OVF_ON));
    tick(100);
    check("sat_issued", 32'(plog_cyc.size()), 32'd18);
    n1 = 0;
    foreach (plog_sel[k]) if (plog_sel[k] == 1) n1++;
    check("sat_all_sel1", 32'(n1), 32'd18);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    @(negedge clk);
    check("sat_cleared", 32'(o_overflow), 32'd0);

    // Reset during HOLD with backlog.
    do_reset();
    tick(3);
    req = 4'b1100;
    tick(1);
    req = '0;
    tick(5);
    rst = 1'b1;
    #1;
    check("midrst_pulse", 32'(o_pulse), 32'd0);
    check("midrst_sel", 32'(o_sel), 32'd0);
    check("midrst_pend", 32'(o_pending_any), 32'd0);
    tick(2);
    rst = 1'b0;
    plog_cyc.delete();
    plog_sel.delete();
    tick(30);
    check("midrst_no_pulse", 32'(plog_cyc.size()), 32'd0);

    // Randomized traffic through the CDC scoreboard.
    do_reset();
    tick(20);
    for (int i = 0; i < N; i++) begin
      rcv[i] = 0;
      m_acc[i] = 0;
    end
    rcv_total = 0;
    tog_cnt = 0;
    underflow = 0;
    acc_en = 1'b1;
    for (int k = 0; k < 2400; k++) begin
      for (int i = 0; i < N; i++) begin
        if (k < 1200) req[i] = ($urandom_range(0, 7) == 0);
        else          req[i] = ($urandom_range(0, 39) == 0);
      end
      clr = ($urandom_range(0, 63) == 0);
      tick(1);
    end
    req = '0;
    clr = 1'b0;
    acc_en = 1'b0;
    tick(600);
    for (int i = 0; i < N; i++) check("rand_rcv_idx", 32'(rcv[i]), 32'(m_acc[i]));
    check("rand_no_merge", 32'(rcv_total), 32'(tog_cnt));
    check("rand_underflow", 32'(underflow), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
